fir_coe_ctrl: RTL and testbench

Command sequencer in front of fir_top's coefficient interface. It accepts host commands to either select a local coefficient bank or stream in a new coefficient set. It drives fir_top's coe_sel/coe_reload ports with exact word counts. It then mutes the FIR output for a programmable number of output samples, so that samples computed with mixed old/new coefficients never reach downstream logic.

---
 rtl/fir_coe_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fir_coe_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coe_ctrl.sv
// rtl/fir_coe_ctrl.sv - command sequencer for fir_top bank select / coefficient reload with output mute
// Optional load watchdog enabled by defining FIR_CTRL_TIMEOUT_EN.
module fir_coe_ctrl #(
   parameter int COE_WIDTH      = 16,
   parameter int COE_TAPS       = 3,
   parameter int COE_SYMMETRY   = 0,
   parameter int COE_LOCAL_NUM  = 2,
   parameter int COE_SEL_WIDTH  = 2,
   parameter int FLUSH_SAMPLES  = 3,
   parameter int CNT_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_vld_i,
   output logic                     cmd_rdy_o,
   input  logic                     cmd_type_i,
   input  logic [COE_SEL_WIDTH-1:0] cmd_index_i,
   input  logic                     wr_vld_i,
   output logic                     wr_rdy_o,
   input  logic [COE_WIDTH-1:0]     wr_data_i,
   output logic                     coe_sel_vld_o,
   output logic [COE_SEL_WIDTH-1:0] coe_sel_index_o,
   output logic                     coe_reload_vld_o,
   output logic [COE_WIDTH-1:0]     coe_reload_data_o,
   input  logic                     fir_vld_i,
   output logic                     mute_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   localparam int NWORDS = (COE_SYMMETRY != 0) ? (COE_TAPS + COE_TAPS % 2) / 2 : COE_TAPS;
   localparam logic [CNT_WIDTH-1:0]     LAST_WORD  = CNT_WIDTH'(NWORDS - 1);
   localparam logic [CNT_WIDTH-1:0]     ALL_WORDS  = CNT_WIDTH'(NWORDS);
   localparam logic [CNT_WIDTH-1:0]     FLUSH_LAST = CNT_WIDTH'(FLUSH_SAMPLES - 1);
   localparam logic [COE_SEL_WIDTH-1:0] RELOAD_IDX = COE_SEL_WIDTH'(COE_LOCAL_NUM);
   localparam logic                     MUTE_EN    = (FLUSH_SAMPLES != 0);

   typedef enum logic [1:0] {IDLE, LOAD, SELECT, FLUSH} state_t;

   state_t                   state, state_nxt;
   logic [CNT_WIDTH-1:0]     word_cnt, word_cnt_nxt;
   logic [CNT_WIDTH-1:0]     flush_cnt, flush_cnt_nxt;
   logic                     cmd_rdy_nxt, wr_rdy_nxt, sel_vld_nxt, reload_vld_nxt;
   logic                     mute_nxt, done_nxt, err_nxt;
   logic [COE_SEL_WIDTH-1:0] sel_index_nxt;
   logic [COE_WIDTH-1:0]     reload_data_nxt;
   logic                     cmd_fire, wr_fire, timeout;

   assign cmd_fire = cmd_vld_i & cmd_rdy_o;
   assign wr_fire  = wr_vld_i & wr_rdy_o;

`ifdef FIR_CTRL_TIMEOUT_EN
   localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   logic [CNT_WIDTH-1:0] idle_cnt, idle_cnt_nxt;

   always_comb begin
      idle_cnt_nxt = '0;
      if (state == LOAD && !wr_fire)
         idle_cnt_nxt = idle_cnt + 1'b1;
   end

   // The drain cycle after the last word is never a stall.
   assign timeout = (state == LOAD) && !wr_fire && (word_cnt != ALL_WORDS) &&
                    (idle_cnt_nxt == IDLE_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt_nxt;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt       = state;
      word_cnt_nxt    = word_cnt;
      flush_cnt_nxt   = flush_cnt;
      cmd_rdy_nxt     = 1'b0;
      wr_rdy_nxt      = 1'b0;
      sel_vld_nxt     = 1'b0;
      reload_vld_nxt  = wr_fire;
      mute_nxt        = 1'b0;
      done_nxt        = 1'b0;
      err_nxt         = 1'b0;
      sel_index_nxt   = coe_sel_index_o;
      reload_data_nxt = wr_fire ? wr_data_i : coe_reload_data_o;

      case (state)
         IDLE: begin
            cmd_rdy_nxt = 1'b1;
            if (cmd_fire) begin
               if (cmd_type_i) begin
                  state_nxt    = LOAD;
                  word_cnt_nxt = '0;
                  cmd_rdy_nxt  = 1'b0;
                  wr_rdy_nxt   = 1'b1;
               end else if (cmd_index_i < RELOAD_IDX) begin
                  state_nxt     = SELECT;
                  cmd_rdy_nxt   = 1'b0;
                  sel_vld_nxt   = 1'b1;
                  sel_index_nxt = cmd_index_i;
                  mute_nxt      = MUTE_EN;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         LOAD: begin
            // word_cnt == ALL_WORDS marks the drain cycle of the last reload pulse.
            if (word_cnt == ALL_WORDS) begin
               state_nxt     = SELECT;
               sel_vld_nxt   = 1'b1;
               sel_index_nxt = RELOAD_IDX;
               mute_nxt      = MUTE_EN;
            end else if (timeout) begin
               state_nxt   = IDLE;
               cmd_rdy_nxt = 1'b1;
               err_nxt     = 1'b1;
            end else begin
               wr_rdy_nxt = !(wr_fire && (word_cnt == LAST_WORD));
               if (wr_fire)
                  word_cnt_nxt = word_cnt + 1'b1;
            end
         end
         SELECT: begin
            flush_cnt_nxt = '0;
            if (FLUSH_SAMPLES == 0) begin
               state_nxt   = IDLE;
               cmd_rdy_nxt = 1'b1;
               done_nxt    = 1'b1;
            end else begin
               state_nxt = FLUSH;
               mute_nxt  = 1'b1;
            end
         end
         FLUSH: begin
            mute_nxt = 1'b1;
            if (fir_vld_i) begin
               flush_cnt_nxt = flush_cnt + 1'b1;
               if (flush_cnt == FLUSH_LAST) begin
                  state_nxt   = IDLE;
                  mute_nxt    = 1'b0;
                  done_nxt    = 1'b1;
                  cmd_rdy_nxt = 1'b1;
               end
            end
         end
         default: begin
            state_nxt   = IDLE;
            cmd_rdy_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         word_cnt          <= '0;
         flush_cnt         <= '0;
         cmd_rdy_o         <= 1'b1;
         wr_rdy_o          <= 1'b0;
         coe_sel_vld_o     <= 1'b0;
         coe_sel_index_o   <= '0;
         coe_reload_vld_o  <= 1'b0;
         coe_reload_data_o <= '0;
         mute_o            <= 1'b0;
         busy_o            <= 1'b0;
         done_o            <= 1'b0;
         err_o             <= 1'b0;
      end else begin
         state             <= state_nxt;
         word_cnt          <= word_cnt_nxt;
         flush_cnt         <= flush_cnt_nxt;
         cmd_rdy_o         <= cmd_rdy_nxt;
         wr_rdy_o          <= wr_rdy_nxt;
         coe_sel_vld_o     <= sel_vld_nxt;
         coe_sel_index_o   <= sel_index_nxt;
         coe_reload_vld_o  <= reload_vld_nxt;
         coe_reload_data_o <= reload_data_nxt;
         mute_o            <= mute_nxt;
         busy_o            <= (state_nxt != IDLE);
         done_o            <= done_nxt;
         err_o             <= err_nxt;
      end
   end

endmodule

// File: tb/tb_fir_coe_ctrl.sv
// tb/tb_fir_coe_ctrl.sv - table-driven and randomized checks for fir_coe_ctrl (plain and symmetric builds)
// Timeout sequence included when FIR_CTRL_TIMEOUT_EN is defined.
module tb_fir_coe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_vld, cmd_type;
   logic [1:0]  cmd_index;
   logic        wr_vld;
   logic [15:0] wr_data;
   logic        fir_vld;

   logic        a_cmd_rdy, a_wr_rdy, a_sel_vld, a_reload_vld, a_mute, a_busy, a_done, a_err;
   logic [1:0]  a_sel_index;
   logic [15:0] a_reload_data;
   logic        b_cmd_rdy, b_wr_rdy, b_sel_vld, b_reload_vld, b_mute, b_busy, b_done, b_err;
   logic [1:0]  b_sel_index;
   logic [15:0] b_reload_data;
   logic [25:0] obs_a, obs_b;

   int          checks = 0;
   int          errors = 0;
   logic [1:0]  exp_sel_index;
   logic [15:0] exp_reload_data;

   always #5 clk = ~clk;

   fir_coe_ctrl #(.COE_TAPS(3), .COE_SYMMETRY(0), .TIMEOUT_CYCLES(10)) dut_a (
      .clk(clk), .rst(rst),
      .cmd_vld_i(cmd_vld), .cmd_rdy_o(a_cmd_rdy), .cmd_type_i(cmd_type), .cmd_index_i(cmd_index),
      .wr_vld_i(wr_vld), .wr_rdy_o(a_wr_rdy), .wr_data_i(wr_data),
      .coe_sel_vld_o(a_sel_vld), .coe_sel_index_o(a_sel_index),
      .coe_reload_vld_o(a_reload_vld), .coe_reload_data_o(a_reload_data),
      .fir_vld_i(fir_vld), .mute_o(a_mute), .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
   );

   // Symmetric 5-tap build also needs exactly 3 words, so both see identical expectations.
   fir_coe_ctrl #(.COE_TAPS(5), .COE_SYMMETRY(1), .TIMEOUT_CYCLES(10)) dut_b (
      .clk(clk), .rst(rst),
      .cmd_vld_i(cmd_vld), .cmd_rdy_o(b_cmd_rdy), .cmd_type_i(cmd_type), .cmd_index_i(cmd_index),
      .wr_vld_i(wr_vld), .wr_rdy_o(b_wr_rdy), .wr_data_i(wr_data),
      .coe_sel_vld_o(b_sel_vld), .coe_sel_index_o(b_sel_index),
      .coe_reload_vld_o(b_reload_vld), .coe_reload_data_o(b_reload_data),
      .fir_vld_i(fir_vld), .mute_o(b_mute), .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
   );

   assign obs_a = {a_cmd_rdy, a_wr_rdy, a_sel_vld, a_sel_index, a_reload_vld, a_reload_data,
                   a_mute, a_busy, a_done, a_err};
   assign obs_b = {b_cmd_rdy, b_wr_rdy, b_sel_vld, b_sel_index, b_reload_vld, b_reload_data,
                   b_mute, b_busy, b_done, b_err};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Field order: cmd_rdy wr_rdy sel_vld sel_index reload_vld reload_data mute busy done err
   function automatic logic [25:0] mk(input logic cr, input logic wr, input logic sv, input logic rv,
                                      input logic mu, input logic bz, input logic dn, input logic er);
      return {cr, wr, sv, exp_sel_index, rv, exp_reload_data, mu, bz, dn, er};
   endfunction

   task automatic chk_both(input string name, input logic [25:0] exp);
      chk({name, " plain"}, 32'(obs_a), 32'(exp));
      chk({name, " sym"}, 32'(obs_b), 32'(exp));
   endtask

   task automatic bad_cmd(input logic [1:0] idx);
      step();
      chk_both("bad_pre", mk(1, 0, 0, 0, 0, 0, 0, 0));
      cmd_vld = 1'b1; cmd_type = 1'b0; cmd_index = idx; fir_vld = 1'b1;
      step();
      cmd_vld = 1'b0; fir_vld = 1'b0;
      chk_both($sformatf("bad_err_idx%0d", idx), mk(1, 0, 0, 0, 0, 0, 0, 1));
      step();
      chk_both("bad_post", mk(1, 0, 0, 0, 0, 0, 0, 0));
   endtask

   // Event-time model: sel at T+1 or two cycles after the last accepted word,
   // mute from sel until three FIR samples after sel, done one cycle later.
   task automatic run_cmd(input logic typ, input logic [1:0] idx, input logic [1:0] sel_idx,
                          input int fir_pct, input bit fixed);
      int          sel_cyc, done_cyc, n_acc, nfir, idle_run;
      bit          acc_prev, exp_wr_rdy, mu, bz;
      logic [15:0] data_prev;
      step();
      chk_both("pre_cmd", mk(1, 0, 0, 0, 0, 0, 0, 0));
      cmd_vld = 1'b1; cmd_type = typ; cmd_index = idx; wr_vld = 1'b0;
      fir_vld = 1'($urandom_range(1));
      sel_cyc = typ ? -1 : 1; done_cyc = -1; n_acc = 0; nfir = 0; idle_run = 0;
      acc_prev = 1'b0; data_prev = '0;
      for (int c = 1; c <= 300; c++) begin
         step();
         exp_wr_rdy = typ && (n_acc < 3);
         if (acc_prev) exp_reload_data = data_prev;
         if (c == sel_cyc) exp_sel_index = sel_idx;
         mu = (sel_cyc > 0) && (c >= sel_cyc) && (c != done_cyc);
         bz = (c != done_cyc);
         chk_both($sformatf("t%0d_i%0d_c%0d", typ, idx, c),
                  mk(!bz, exp_wr_rdy, c == sel_cyc, acc_prev, mu, bz, c == done_cyc, 1'b0));
         if (c == done_cyc) begin
            cmd_vld = 1'b0; wr_vld = 1'b0; fir_vld = 1'b0;
            break;
         end
         cmd_vld = 1'($urandom_range(1));
         cmd_type = 1'($urandom_range(1));
         if (fixed) begin
            wr_vld  = exp_wr_rdy;
            wr_data = 16'h0101 * 16'(n_acc + 1);
         end else begin
            wr_vld  = (idle_run >= 3) || ($urandom_range(1) == 1);
            wr_data = 16'($urandom);
         end
         acc_prev  = wr_vld && exp_wr_rdy;
         data_prev = wr_data;
         idle_run  = (exp_wr_rdy && !acc_prev) ? idle_run + 1 : 0;
         if (acc_prev) begin
            n_acc++;
            if (n_acc == 3) sel_cyc = c + 2;
         end
         fir_vld = ($urandom_range(99) < fir_pct);
         if (fir_vld && sel_cyc > 0 && c > sel_cyc && done_cyc < 0) begin
            nfir++;
            if (nfir == 3) done_cyc = c + 1;
         end
      end
      if (done_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL cmd_complete: done not reached within budget (type %0d index %0d)", typ, idx);
         cmd_vld = 1'b0; wr_vld = 1'b0; fir_vld = 1'b0;
      end
   endtask

   typedef struct {
      logic       typ;
      logic [1:0] idx;
      logic       exp_err;
      logic [1:0] exp_sel;
      int         fir_pct;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b0, 2'd1, 1'b0, 2'd1, 100};
      vecs[1] = '{1'b0, 2'd0, 1'b0, 2'd0, 40};
      vecs[2] = '{1'b0, 2'd2, 1'b1, 2'd0, 0};
      vecs[3] = '{1'b1, 2'd0, 1'b0, 2'd2, 60};
      vecs[4] = '{1'b0, 2'd3, 1'b1, 2'd0, 0};
      vecs[5] = '{1'b1, 2'd3, 1'b0, 2'd2, 25};

      rst = 1'b1; cmd_vld = 1'b0; cmd_type = 1'b0; cmd_index = '0;
      wr_vld = 1'b0; wr_data = '0; fir_vld = 1'b0;
      exp_sel_index = '0; exp_reload_data = '0;
      step();
      step();
      chk_both("reset", mk(1, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].exp_err)
            bad_cmd(vecs[i].idx);
         else
            run_cmd(vecs[i].typ, vecs[i].idx, vecs[i].exp_sel, vecs[i].fir_pct, 1'b0);
      end

      run_cmd(1'b1, 2'd0, 2'd2, 100, 1'b1);

      for (int i = 0; i < 24; i++) begin
         logic       typ;
         logic [1:0] idx;
         typ = 1'($urandom_range(1));
         idx = 2'($urandom_range(3));
         if (!typ && idx >= 2)
            bad_cmd(idx);
         else
            run_cmd(typ, idx, typ ? 2'd2 : idx, int'($urandom_range(90, 10)), 1'b0);
      end

      // Reset after two of three reload words.
      step();
      cmd_vld = 1'b1; cmd_type = 1'b1;
      step();
      cmd_vld = 1'b0; wr_vld = 1'b1; wr_data = 16'h1111;
      step();
      wr_data = 16'h2222;
      step();
      wr_vld = 1'b0;
      exp_reload_data = 16'h2222;
      chk_both("rst_before", mk(0, 1, 0, 1, 0, 1, 0, 0));
      #3 rst = 1'b1;
      #1;
      exp_sel_index = '0;
      exp_reload_data = '0;
      chk_both("rst_async", mk(1, 0, 0, 0, 0, 0, 0, 0));
      step();
      step();
      rst = 1'b0;
      run_cmd(1'b1, 2'd0, 2'd2, 100, 1'b1);

`ifdef FIR_CTRL_TIMEOUT_EN
      step();
      chk_both("to_pre", mk(1, 0, 0, 0, 0, 0, 0, 0));
      cmd_vld = 1'b1; cmd_type = 1'b1;
      step();
      cmd_vld = 1'b0; wr_vld = 1'b1; wr_data = 16'h0abc;
      chk_both("to_load", mk(0, 1, 0, 0, 0, 1, 0, 0));
      for (int k = 1; k <= 10; k++) begin
         step();
         wr_vld = 1'b0;
         if (k == 1) exp_reload_data = 16'h0abc;
         chk_both($sformatf("to_k%0d", k),
                  (k == 10) ? mk(1, 0, 0, 0, 0, 0, 0, 1) : mk(0, 1, 0, k == 1, 0, 1, 0, 0));
      end
      step();
      chk_both("to_post", mk(1, 0, 0, 0, 0, 0, 0, 0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
